// File: rtl/phase_pair_gen_if.sv
// phase_pair_gen_if
//   Bundles the command and waveform signals of phase_pair_gen.
//   master : drives start/delay/half_per/n_cycles/stop, observes waves and status
//   slave  : the generator; drives X1/X2/busy/done/ret_teor
//   start     request, sampled only while the generator is idle
//   delay     signed X2 lag (+) / lead (-) in clk ticks
//   half_per  ticks both-high and both-low per period
//   n_cycles  number of full periods to emit
//   stop      graceful abort, current period still completes
//   X1, X2    registered square waves
//   busy      burst in progress
//   done      one-cycle pulse after the last period
//   ret_teor  signed delay of the running (or last) burst
interface phase_pair_gen_if #(
    parameter int DLY_W = 8,
    parameter int PER_W = 10,
    parameter int CYC_W = 8
);
    logic                    start;
    logic signed [DLY_W-1:0] delay;
    logic        [PER_W-1:0] half_per;
    logic        [CYC_W-1:0] n_cycles;
    logic                    stop;
    logic                    X1;
    logic                    X2;
    logic                    busy;
    logic                    done;
    logic signed [DLY_W-1:0] ret_teor;

    modport master (
        output start, delay, half_per, n_cycles, stop,
        input  X1, X2, busy, done, ret_teor
    );

    modport slave (
        input  start, delay, half_per, n_cycles, stop,
        output X1, X2, busy, done, ret_teor
    );
endinterface

// File: rtl/phase_pair_gen.sv
// phase_pair_gen
//   Emits two phase-shifted square waves X1/X2 for the ToF estimator chain.
//   Each period: PH_A (|delay| ticks, one wave leads), PH_B (half-period,
//   both high), PH_C (|delay| ticks, other wave high), PH_D (half-period,
//   both low). Positive delay makes X2 lag X1, negative makes it lead.
//   Ports: clk, reset (synchronous, active high), bus (phase_pair_gen_if.slave).
//   Optional macro PHASE_NOISE_EN adds per-period duration dither from an
//   8-bit LFSR; ret_teor always reports the un-dithered command.
//
//   state | meaning
//   IDLE  | waiting for start
//   PH_A  | leading wave alone high (mag ticks)
//   PH_B  | both high (half-period ticks)
//   PH_C  | trailing wave alone high (mag ticks)
//   PH_D  | both low (half-period ticks), period accounting at its end
//   DONE  | one-cycle done pulse, then IDLE
module phase_pair_gen #(
    parameter int DLY_W = 8,
    parameter int PER_W = 10,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    phase_pair_gen_if.slave  bus
);
    localparam int CNT_W = PER_W + 1;
    localparam int MAG_W = DLY_W + 1;

    typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] len_a, len_b, len_a_nx, len_b_nx;
    logic [CYC_W-1:0] cyc_cnt, cyc_nx, n_r;
    logic [MAG_W-1:0] dly_ext, in_mag, mag_r, src_mag;
    logic [PER_W-1:0] hp_r, src_hp;
    logic             lead_r, src_lead;
    logic             stop_flag, stop_seen;
    logic             accept, period_start;
    logic             x1_nx, x2_nx;

    // Magnitude needs one extra bit so that the most negative delay fits.
    assign dly_ext   = {bus.delay[DLY_W-1], bus.delay};
    assign in_mag    = dly_ext[MAG_W-1] ? (~dly_ext + MAG_W'(1)) : dly_ext;

    // In IDLE the only period start is burst acceptance, so durations and
    // direction come straight from the command inputs there.
    assign src_mag   = (state == IDLE) ? in_mag : mag_r;
    assign src_hp    = (state == IDLE) ? bus.half_per : hp_r;
    assign src_lead  = (state == IDLE) ? bus.delay[DLY_W-1] : lead_r;

    assign stop_seen = stop_flag | (bus.busy & bus.stop);

`ifdef PHASE_NOISE_EN
    logic [7:0]        lfsr, lfsr_nx;
    logic signed [2:0] noise, noise_half;
    logic [CNT_W:0]    mag_s, hp_s;

    assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_comb begin
        noise = $signed(lfsr_nx[2:0]);
        if (lfsr_nx[2:0] == 3'b100) noise = -3'sd3;
        noise_half = 3'sd0;
        if (noise > 3'sd1)  noise_half = 3'sd1;
        if (noise < -3'sd1) noise_half = -3'sd1;
        mag_s = (CNT_W+1)'(src_mag) + (CNT_W+1)'(noise_half);
        hp_s  = (CNT_W+1)'(src_hp) + (CNT_W+1)'(noise);
        len_a_nx = mag_s[CNT_W] ? '0 : mag_s[CNT_W-1:0];
        len_b_nx = (hp_s[CNT_W] || hp_s == '0) ? CNT_W'(1) : hp_s[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)             lfsr <= 8'hA5;
        else if (period_start) lfsr <= lfsr_nx;
    end
`else
    assign len_a_nx = CNT_W'(src_mag);
    assign len_b_nx = (src_hp == '0) ? CNT_W'(1) : CNT_W'(src_hp);
`endif

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + CNT_W'(1);
        cyc_nx       = cyc_cnt;
        accept       = 1'b0;
        period_start = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (bus.start) begin
                    if (bus.n_cycles == '0) begin
                        state_nx = DONE;
                    end else begin
                        accept       = 1'b1;
                        period_start = 1'b1;
                        cyc_nx       = '0;
                    end
                end
            end
            PH_A: if (cnt == len_a - CNT_W'(1)) begin
                state_nx = PH_B;
                cnt_nx   = '0;
            end
            PH_B: if (cnt == len_b - CNT_W'(1)) begin
                state_nx = (len_a == '0) ? PH_D : PH_C;
                cnt_nx   = '0;
            end
            PH_C: if (cnt == len_a - CNT_W'(1)) begin
                state_nx = PH_D;
                cnt_nx   = '0;
            end
            PH_D: if (cnt == len_b - CNT_W'(1)) begin
                cyc_nx = cyc_cnt + CYC_W'(1);
                cnt_nx = '0;
                if (cyc_nx == n_r || stop_seen) state_nx = DONE;
                else                            period_start = 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase

        // A zero-length lead phase is skipped entirely.
        if (period_start) begin
            state_nx = (len_a_nx == '0) ? PH_B : PH_A;
            cnt_nx   = '0;
        end

        // Waves are registered from the next state so they track the FSM.
        x1_nx = 1'b0;
        x2_nx = 1'b0;
        case (state_nx)
            PH_A: begin x1_nx = ~src_lead; x2_nx = src_lead;  end
            PH_B: begin x1_nx = 1'b1;      x2_nx = 1'b1;      end
            PH_C: begin x1_nx = src_lead;  x2_nx = ~src_lead; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cyc_cnt      <= '0;
            n_r          <= '0;
            mag_r        <= '0;
            hp_r         <= '0;
            lead_r       <= 1'b0;
            len_a        <= '0;
            len_b        <= '0;
            stop_flag    <= 1'b0;
            bus.X1       <= 1'b0;
            bus.X2       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ret_teor <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cyc_cnt  <= cyc_nx;
            bus.X1   <= x1_nx;
            bus.X2   <= x2_nx;
            bus.busy <= (state_nx == PH_A) || (state_nx == PH_B) ||
                        (state_nx == PH_C) || (state_nx == PH_D);
            bus.done <= (state_nx == DONE);
            if (accept) begin
                mag_r        <= in_mag;
                hp_r         <= bus.half_per;
                n_r          <= bus.n_cycles;
                lead_r       <= bus.delay[DLY_W-1];
                bus.ret_teor <= bus.delay;
            end
            if (period_start) begin
                len_a <= len_a_nx;
                len_b <= len_b_nx;
            end
            if (state == IDLE)             stop_flag <= 1'b0;
            else if (bus.busy && bus.stop) stop_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_phase_pair_gen.sv
// tb_phase_pair_gen
//   Directed bench for phase_pair_gen: a table of bursts with hand-computed
//   wave timing, plus reset-in-burst and reset-state sequences.
//   Times t are counted in clk ticks after the edge that accepts start.
module tb_phase_pair_gen;
    localparam int DLY_W = 8;
    localparam int PER_W = 10;
    localparam int CYC_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    phase_pair_gen_if #(.DLY_W(DLY_W), .PER_W(PER_W), .CYC_W(CYC_W)) bus ();

    phase_pair_gen #(.DLY_W(DLY_W), .PER_W(PER_W), .CYC_W(CYC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dly;
        int hp;
        int n;
        int stop_at;     // tick at which a one-cycle stop pulse is driven, -1 none
        int restart_at;  // tick at which a competing start is driven, -1 none
        int e_x1r;       // first tick with X1 high, -1 never
        int e_x2r;       // first tick with X2 high, -1 never
        int e_done;      // tick at which done is seen
        int e_high;      // ticks with X1 high
        int e_diff;      // ticks with X1 != X2
        int e_rises;     // X1 rising edges
        int e_busy0;     // busy at t=0
        int e_ret;       // ret_teor at done
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v, input int limit,
                             output int x1r, output int x2r, output int done_t,
                             output int high, output int diff, output int rises,
                             output int busy0, output int ret, output int busy_at_done,
                             output int done_after);
        bit prev1;
        x1r = -1; x2r = -1; done_t = -1; high = 0; diff = 0; rises = 0;
        busy0 = -1; ret = 0; busy_at_done = -1; done_after = -1; prev1 = 1'b0;
        @(negedge clk);
        bus.delay    = DLY_W'(v.dly);
        bus.half_per = PER_W'(v.hp);
        bus.n_cycles = CYC_W'(v.n);
        bus.start    = 1'b1;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (t == 0) busy0 = int'(bus.busy);
            if (bus.X1 && x1r < 0) x1r = t;
            if (bus.X2 && x2r < 0) x2r = t;
            if (bus.X1 && !prev1) rises++;
            prev1 = bus.X1;
            if (bus.X1) high++;
            if (bus.X1 != bus.X2) diff++;
            if (t == v.stop_at) bus.stop = 1'b1;
            if (t == v.restart_at) begin
                bus.delay    = -8'sd7;
                bus.n_cycles = 8'd5;
                bus.start    = 1'b1;
            end
            if (bus.done) begin
                done_t       = t;
                ret          = int'(bus.ret_teor);
                busy_at_done = int'(bus.busy);
                break;
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        if (done_t >= 0) begin
            @(negedge clk);
            done_after = int'(bus.done);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x1r, x2r, done_t, high, diff, rises, busy0, ret, bad, quiet, busy_d, done_a;

        //            dly  hp  n  stop rst  x1r x2r done high diff ris b0 ret
        vecs[0]  = '{  10, 150, 2,  -1, -1,   0,  10, 640, 320,  40, 2, 1,  10};
        vecs[1]  = '{ -65, 150, 6,  -1, -1,  65,   0,2580,1290, 780, 6, 1, -65};
        vecs[2]  = '{   0, 150, 3,  -1, -1,   0,   0, 900, 450,   0, 3, 1,   0};
        vecs[3]  = '{-128,  20, 2,  -1, -1, 128,   0, 592, 296, 512, 2, 1,-128};
        vecs[4]  = '{   3,   0, 2,  -1, -1,   0,   3,  16,   8,  12, 2, 1,   3};
        vecs[5]  = '{ 127,   1, 1,  -1, -1,   0, 127, 256, 128, 254, 1, 1, 127};
        vecs[6]  = '{  -1,   5, 4,  -1, -1,   1,   0,  48,  24,   8, 4, 1,  -1};
        vecs[7]  = '{   9,   9, 0,  -1, -1,  -1,  -1,   0,   0,   0, 0, 0,  -1};
        vecs[8]  = '{  10, 150, 6, 400, -1,   0,  10, 640, 320,  40, 2, 1,  10};
        vecs[9]  = '{   5,  10, 2,  -1, 20,   0,   5,  60,  30,  20, 2, 1,   5};
        vecs[10] = '{   2,   3, 3,  -1, -1,   0,   2,  30,  15,  12, 3, 1,   2};
        vecs[11] = '{   0,   0, 2,  -1, -1,   0,   0,   4,   2,   0, 2, 1,   0};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.delay    = '0;
        bus.half_per = '0;
        bus.n_cycles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_x1", int'(bus.X1), 0);
        chk("reset_x2", int'(bus.X2), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_ret", int'(bus.ret_teor), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_burst(vecs[i], 4000, x1r, x2r, done_t, high, diff, rises, busy0, ret,
                      busy_d, done_a);
            chk($sformatf("v%0d_x1_rise", i), x1r, vecs[i].e_x1r);
            chk($sformatf("v%0d_x2_rise", i), x2r, vecs[i].e_x2r);
            chk($sformatf("v%0d_done_tick", i), done_t, vecs[i].e_done);
            chk($sformatf("v%0d_x1_high", i), high, vecs[i].e_high);
            chk($sformatf("v%0d_x1_ne_x2", i), diff, vecs[i].e_diff);
            chk($sformatf("v%0d_x1_rises", i), rises, vecs[i].e_rises);
            chk($sformatf("v%0d_busy_t0", i), busy0, vecs[i].e_busy0);
            chk($sformatf("v%0d_ret_teor", i), ret, vecs[i].e_ret);
            chk($sformatf("v%0d_busy_at_done", i), busy_d, 0);
            chk($sformatf("v%0d_done_width", i), done_a, 0);
        end

        // Reset in the middle of PH_C (t=160..169 for delay 10, half_per 150).
        @(negedge clk);
        bus.delay    = 8'sd10;
        bus.half_per = 10'd150;
        bus.n_cycles = 8'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (165) @(negedge clk);
        chk("phc_x1", int'(bus.X1), 0);
        chk("phc_x2", int'(bus.X2), 1);
        chk("phc_busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bad = int'(bus.X1) + int'(bus.X2) + int'(bus.busy) + int'(bus.done);
        chk("midreset_outputs", bad, 0);
        chk("midreset_ret", int'(bus.ret_teor), 0);
        @(negedge clk);
        reset = 1'b0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.X1 || bus.X2) quiet++;
        end
        chk("midreset_no_done", quiet, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
